// File: rtl/sample_stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : sample_stream_packer
// Description : Packs 16-bit samples into 32-bit words, queues them and
//               serves them as bus read registers. PACK_FLUSH_EN builds the
//               idle-timeout flush of a lone trailing sample.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_stream_packer #(
    parameter int POSITION     = 243,
    parameter int DEPTH        = 8,
    parameter int FLUSH_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic        cs,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] cmd_data_in,
    output logic [31:0] data_out,
    input  logic [15:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic        words_available
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam int c_tmr_w = $clog2(FLUSH_CYCLES + 1);
    localparam logic [7:0] c_reg_data    = 8'd1;
    localparam logic [7:0] c_reg_status  = 8'd2;
    localparam logic [7:0] c_reg_control = 8'd3;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REQ_LO    = 3'd1,
        S_CAP_LO    = 3'd2,
        S_HOLD      = 3'd3,
        S_REQ_HI    = 3'd4,
        S_CAP_HI    = 3'd5,
        S_PUSH      = 3'd6,
        S_PUSH_PART = 3'd7
    } state_t;

    state_t               r_state, w_state_nxt;
    logic                 w_sel, w_rd_hit, w_clear_hit, w_clear;
    logic                 w_pop, w_push, w_flush_fire;
    logic [31:0]          w_push_word;
    logic [15:0]          w_flush_count;
    logic                 r_rd_d1, r_rd_d2, r_clear_d;
    logic [31:0]          r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic [15:0]          r_lo, r_hi;
    logic [c_tmr_w-1:0]   r_timer;

    assign w_sel       = cs & (addr[15:8] == 8'(POSITION));
    assign w_rd_hit    = w_sel & rd & (addr[7:0] == c_reg_data);
    assign w_clear_hit = w_sel & wr & (addr[7:0] == c_reg_control) & (cmd_data_in == 32'd1);
    assign w_clear     = w_clear_hit & ~r_clear_d;
    // Pop on the falling edge of the delayed read strobe; ignored when empty
    assign w_pop       = r_rd_d2 & ~r_rd_d1 & (r_count != '0);
    assign words_available = (r_count != '0);

`ifdef PACK_FLUSH_EN
    logic [15:0] r_flush_count;
    assign w_flush_fire  = (r_timer == c_tmr_w'(FLUSH_CYCLES - 1));
    assign w_flush_count = r_flush_count;

    always_ff @(posedge clk) begin
        if (rst || w_clear)
            r_flush_count <= '0;
        else if (r_state == S_PUSH_PART && r_flush_count != 16'hFFFF)
            r_flush_count <= r_flush_count + 16'd1;
    end
`else
    assign w_flush_fire  = 1'b0;
    assign w_flush_count = 16'h0000;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        fifo_rd_en  = 1'b0;
        w_push      = 1'b0;
        w_push_word = {r_hi, r_lo};
        case (r_state)
            S_IDLE:   if (!fifo_empty && r_count < c_depth) w_state_nxt = S_REQ_LO;
            S_REQ_LO: begin
                if (fifo_empty) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    fifo_rd_en  = 1'b1;
                    w_state_nxt = S_CAP_LO;
                end
            end
            S_CAP_LO: w_state_nxt = fifo_empty ? S_HOLD : S_REQ_HI;
            S_HOLD: begin
                if (!fifo_empty)
                    w_state_nxt = S_REQ_HI;
                else if (w_flush_fire)
                    w_state_nxt = S_PUSH_PART;
            end
            S_REQ_HI: begin
                if (fifo_empty) begin
                    w_state_nxt = S_HOLD;
                end else begin
                    fifo_rd_en  = 1'b1;
                    w_state_nxt = S_CAP_HI;
                end
            end
            S_CAP_HI: w_state_nxt = S_PUSH;
            S_PUSH: begin
                w_push      = 1'b1;
                w_state_nxt = S_IDLE;
            end
`ifdef PACK_FLUSH_EN
            S_PUSH_PART: begin
                w_push      = 1'b1;
                w_push_word = {16'h0000, r_lo};
                w_state_nxt = S_IDLE;
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_clear)
            w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lo      <= '0;
            r_hi      <= '0;
            r_timer   <= '0;
            r_rd_d1   <= 1'b0;
            r_rd_d2   <= 1'b0;
            r_clear_d <= 1'b0;
        end else begin
            r_rd_d1   <= w_rd_hit;
            r_rd_d2   <= r_rd_d1;
            r_clear_d <= w_clear_hit;
            if (w_clear) begin
                r_lo    <= '0;
                r_hi    <= '0;
                r_timer <= '0;
            end else begin
                case (r_state)
                    S_CAP_LO: begin
                        r_lo    <= fifo_dout;
                        r_timer <= '0;
                    end
                    S_HOLD: begin
                        r_timer <= r_timer + c_tmr_w'(1);
                        if (fifo_empty && w_flush_fire)
                            r_hi <= '0;
                    end
                    S_CAP_HI: r_hi <= fifo_dout;
                    default: ;
                endcase
            end
        end
    end

    // Clear wins over a same-cycle push or pop
    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !w_clear && w_push)
            r_mem[r_wr_ptr] <= w_push_word;
    end

    always_ff @(posedge clk) begin
        if (rst || !w_sel) begin
            data_out <= '0;
        end else begin
            case (addr[7:0])
                c_reg_data:   data_out <= (r_count != '0) ? r_mem[r_rd_ptr] : 32'd0;
                c_reg_status: data_out <= {w_flush_count, 12'h000, 4'(r_count)};
                default:      data_out <= '0;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: doc/sample_stream_packer.md
Name: sample_stream_packer

Overview:
- Downstream of the sample collector: drains its 16-bit sample FIFO, packs consecutive samples into 32-bit words, buffers them in a small output queue, and exposes them to the host command bus as read registers.
- Halves host read transactions per sample.
- Optional idle-timeout flush emits a lone trailing sample.

Parameters:
- POSITION, 243, bus slot. Block selected when addr[15:8]==POSITION.
- DEPTH, 8, output queue depth in 32-bit words; must be a power of 2, at least 2.
- FLUSH_CYCLES, 1024, idle cycles before a half-filled word is flushed (only with the optional feature).

Ports:
- clk in 1: clock.
- rst in 1: synchronous, active-high reset.
- addr in 16: command bus address.
- cs in 1: chip select.
- rd in 1: bus read strobe, level; held for a multi-cycle transaction.
- wr in 1: bus write strobe.
- cmd_data_in in 32: bus write data.
- data_out out 32: registered read data.
- fifo_dout in 16: sample FIFO data; valid the cycle after fifo_rd_en.
- fifo_empty in 1: sample FIFO empty.
- fifo_rd_en out 1: sample FIFO pop.
- words_available out 1: queue not empty.

Behaviour:
- Reset: data_out=0, fifo_rd_en=0, words_available=0, queue empty, FSM=IDLE, lo/hi holding registers=0, idle timer=0, flush count=0.
- sel = cs & (addr[15:8]==POSITION).
- Register map on addr[7:0]:
  - 1 DATA (read): queue head word.
  - 2 STATUS (read): {flush_count[15:0], 12'b0, count[3:0]}.
  - 3 CONTROL (write): value 1 = clear.
- data_out is registered every cycle from the register map:
  - DATA with queue empty reads 0.
  - Unmapped addresses read 0.
  - Latency is 1 cycle after addr/cs become stable.
- Pop: on the falling edge of (rd & sel & addr[7:0]==1), detected via a 2-stage delay, the head is popped once per transaction. A pop on an empty queue is ignored.
- FSM:
  - IDLE: if !fifo_empty & count<DEPTH, go to REQ_LO.
  - REQ_LO: fifo_rd_en=1 for one cycle; go to CAP_LO.
  - CAP_LO: lo<=fifo_dout; timer<=0; go to REQ_HI if !fifo_empty, else HOLD.
  - HOLD: timer++ each cycle. If !fifo_empty, go to REQ_HI. With the optional feature, if timer==FLUSH_CYCLES-1, set hi<=0 and go to PUSH_PART.
  - REQ_HI: fifo_rd_en=1; go to CAP_HI.
  - CAP_HI: hi<=fifo_dout; go to PUSH.
  - PUSH: enqueue {hi,lo}; go to IDLE.
  - PUSH_PART: enqueue {16'h0000,lo}; flush_count++ (saturating at 16'hFFFF); go to IDLE.
- fifo_rd_en is never asserted when fifo_empty=1 at the same edge.
- Space is reserved at REQ_LO, so PUSH never sees a full queue.
- Packing order: first sample in [15:0], second sample in [31:16].
- Push and pop in the same cycle: count unchanged, pointers both advance.
- Pointers wrap modulo DEPTH. count is 0..DEPTH.
- CONTROL clear (write of 1, sel&wr, acted on the first cycle seen):
  - Empties the queue, returns FSM to IDLE, discards any half-filled word, zeroes flush_count.
  - The cycle takes priority over a simultaneous push or pop.
  - If clear coincides with a CAP state, the captured FIFO word is lost (accepted).
- Reset mid-operation behaves as reset; the pending half word is lost.
- words_available = (count!=0), combinational from count.

Optional Feature:
- PACK_FLUSH_EN defined: the HOLD timeout path and PUSH_PART are built, and flush_count counts partial words.
- PACK_FLUSH_EN undefined: HOLD waits indefinitely for a second sample, PUSH_PART does not exist, and flush_count reads 0.

Test Plan:
- FIFO preloaded with 16'h1111, 16'h2222 → one word 32'h2222_1111; STATUS count=1. A DATA read returns it; after rd falls, count=0 and words_available=0.
- 2*DEPTH+2 samples in FIFO, no host reads → queue stops at count=DEPTH with no fifo_rd_en while full. Then DEPTH reads → words returned in order; FSM resumes; pointers wrap correctly.
- PACK_FLUSH_EN, single sample 16'hABCD, then FIFO empty → 32'h0000_ABCD enqueued exactly FLUSH_CYCLES cycles after CAP_LO; flush_count=1. Without the macro, no word appears after 4*FLUSH_CYCLES cycles.
- Read transaction (rd held 3 cycles) whose falling edge coincides with PUSH → count unchanged, head advances, new word at tail.
- CONTROL write 1 while count=3 and in HOLD → next cycle count=0, FSM=IDLE, flush_count=0. A subsequent sample pair packs correctly.
- rd held with queue empty → data_out=0, no underflow, count stays 0. A read at addr 0xF5 reads 0 and does not pop.
